// File: rtl/cci_mpf_csrs_pkg.sv
// rtl/cci_mpf_csrs_pkg.sv - shared types and constants for the MPF shim CSR block
// Contents: VTP mode struct, register offsets, DFH value, event count, window helper.
package cci_mpf_csrs_pkg;

    localparam int CCI_MPF_VTP_MODE_W = 2;

    typedef struct packed {
        logic inval_translation_cache;
        logic enable;
    } t_cci_mpf_vtp_csr_mode;

    localparam int CCI_MPF_CSR_NUM_EVENTS = 5;
    localparam int CCI_MPF_CSR_RSP_W      = 9 + 64;

    // Feature type 1 in the top nibble, no next-feature link.
    localparam logic [63:0] CCI_MPF_CSR_DFH = 64'h1000_0000_0000_0001;

    // Register offsets; offset k lives at dword CSR_BASE + 2k.
    localparam logic [3:0] CCI_MPF_CSR_OFF_DFH              = 4'd0;
    localparam logic [3:0] CCI_MPF_CSR_OFF_VTP_MODE         = 4'd1;
    localparam logic [3:0] CCI_MPF_CSR_OFF_PT_BASE          = 4'd2;
    localparam logic [3:0] CCI_MPF_CSR_OFF_VC_MAP_CTRL      = 4'd3;
    localparam logic [3:0] CCI_MPF_CSR_OFF_EVT_BASE         = 4'd4;
    localparam logic [3:0] CCI_MPF_CSR_OFF_WRO_WRITES       = 4'd9;
    localparam logic [3:0] CCI_MPF_CSR_OFF_WRO_READS        = 4'd10;
    localparam logic [3:0] CCI_MPF_CSR_OFF_WRO_WR_CONFLICTS = 4'd11;
    localparam logic [3:0] CCI_MPF_CSR_OFF_WRO_RD_CONFLICTS = 4'd12;

    // rel is the dword address minus CSR_BASE; the window spans 16 offsets = 32 dwords.
    function automatic logic csr_in_window(input logic [15:0] rel);
        return rel < 16'd32;
    endfunction

endpackage

// File: rtl/cci_mpf_shim_csr_ctrl_if.sv
// rtl/cci_mpf_shim_csr_ctrl_if.sv - MMIO request/response bundle for the CSR controller
// slave: the CSR controller (consumes MMIO requests, produces responses).
// master: the host side.
interface cci_mpf_shim_csr_ctrl_if;
    logic        mmio_wr_valid;
    logic [15:0] mmio_wr_addr;
    logic [63:0] mmio_wr_data;
    logic        mmio_rd_valid;
    logic [15:0] mmio_rd_addr;
    logic [8:0]  mmio_rd_tid;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        rsp_ready;
    logic        rsp_overflow;

    modport slave (
        input  mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
        input  mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        input  rsp_ready,
        output rsp_valid, rsp_tid, rsp_data, rsp_overflow
    );

    modport master (
        output mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
        output mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        output rsp_ready,
        input  rsp_valid, rsp_tid, rsp_data, rsp_overflow
    );
endinterface

// File: rtl/cci_mpf_csr_rsp_fifo.sv
// rtl/cci_mpf_csr_rsp_fifo.sv - read-response FIFO for the CSR controller
// Ports: enq_data/enq_en push, deq_en pop, first head entry, notEmpty, full.
// An enqueue while full is accepted only when a dequeue happens in the same cycle.
module cci_mpf_csr_rsp_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             enq_en,
    input  logic             deq_en,
    output logic [WIDTH-1:0] first,
    output logic             notEmpty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_enq;
    logic             do_deq;

    assign do_deq = deq_en && notEmpty;
    assign do_enq = enq_en && (!full || do_deq);

    always_comb begin
        count_next = count;
        if (do_enq && !do_deq) begin
            count_next = count + 1'b1;
        end else if (!do_enq && do_deq) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            notEmpty <= 1'b0;
            full     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            notEmpty <= (count_next != '0);
            full     <= (count_next == CW'(DEPTH));
        end
    end

    // Head entry comes straight from the storage flops.
    assign first = mem[rd_ptr];

endmodule

// File: rtl/cci_mpf_shim_csr_ctrl.sv
// rtl/cci_mpf_shim_csr_ctrl.sv - MMIO CSR controller for the MPF shim
// Ports: clk, reset_n; mmio (slave modport: MMIO writes/reads, buffered responses);
// vtp_in_* and vc_map_ctrl* configuration outputs; vtp_events pulses;
// wro_num_* counters read back as passthrough.
module cci_mpf_shim_csr_ctrl
    import cci_mpf_csrs_pkg::*;
#(
    parameter logic [15:0] CSR_BASE       = 16'h0000,
    parameter int          RSP_FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    cci_mpf_shim_csr_ctrl_if.slave              mmio,
    output t_cci_mpf_vtp_csr_mode               vtp_in_mode,
    output logic [41:0]                         vtp_in_page_table_base,
    output logic                                vtp_in_page_table_base_valid,
    output logic [63:0]                         vc_map_ctrl,
    output logic                                vc_map_ctrl_valid,
    input  logic [CCI_MPF_CSR_NUM_EVENTS-1:0]   vtp_events,
    input  logic [63:0]                         wro_num_writes,
    input  logic [63:0]                         wro_num_reads,
    input  logic [63:0]                         wro_num_write_conflicts,
    input  logic [63:0]                         wro_num_read_conflicts
);
    // Address decode: relative dword index, offset = rel/2, odd dwords are holes.
    logic [15:0] wr_rel;
    logic [15:0] rd_rel;
    logic        wr_hit;
    logic [3:0]  wr_off;
    logic        rd_hit;

    assign wr_rel = mmio.mmio_wr_addr - CSR_BASE;
    assign rd_rel = mmio.mmio_rd_addr - CSR_BASE;
    assign wr_hit = mmio.mmio_wr_valid && csr_in_window(wr_rel) && !wr_rel[0];
    assign wr_off = wr_rel[4:1];
    assign rd_hit = mmio.mmio_rd_valid && csr_in_window(rd_rel);

    // Configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vtp_in_mode                  <= '0;
            vtp_in_page_table_base       <= '0;
            vtp_in_page_table_base_valid <= 1'b0;
            vc_map_ctrl                  <= '0;
            vc_map_ctrl_valid            <= 1'b0;
        end else begin
            vc_map_ctrl_valid <= 1'b0;
            if (wr_hit) begin
                case (wr_off)
                    CCI_MPF_CSR_OFF_VTP_MODE: begin
                        vtp_in_mode <= t_cci_mpf_vtp_csr_mode'(mmio.mmio_wr_data[CCI_MPF_VTP_MODE_W-1:0]);
                    end
                    CCI_MPF_CSR_OFF_PT_BASE: begin
                        vtp_in_page_table_base       <= mmio.mmio_wr_data[41:0];
                        vtp_in_page_table_base_valid <= 1'b1;
                    end
                    CCI_MPF_CSR_OFF_VC_MAP_CTRL: begin
                        vc_map_ctrl       <= mmio.mmio_wr_data;
                        vc_map_ctrl_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Event counters: pulses are registered once before counting; a clear wins.
    logic [CCI_MPF_CSR_NUM_EVENTS-1:0] ev_q;
    logic [CCI_MPF_CSR_NUM_EVENTS-1:0] evt_clr;
    logic [63:0]                       evt_cnt [CCI_MPF_CSR_NUM_EVENTS];

    always_comb begin
        evt_clr = '0;
        for (int i = 0; i < CCI_MPF_CSR_NUM_EVENTS; i++) begin
            evt_clr[i] = wr_hit && (wr_off == CCI_MPF_CSR_OFF_EVT_BASE + 4'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_q <= '0;
            for (int i = 0; i < CCI_MPF_CSR_NUM_EVENTS; i++) begin
                evt_cnt[i] <= '0;
            end
        end else begin
            ev_q <= vtp_events;
            for (int i = 0; i < CCI_MPF_CSR_NUM_EVENTS; i++) begin
                if (evt_clr[i]) begin
                    evt_cnt[i] <= '0;
                end else if (ev_q[i]) begin
                    evt_cnt[i] <= evt_cnt[i] + 64'd1;
                end
            end
        end
    end

    // Read sequencer: S0 captures the request, S1 holds it while register
    // data is muxed and pushed. Sampling in S1 lets a write issued alongside
    // the read land first.
    logic       s0_valid, s1_valid;
    logic [8:0] s0_tid, s1_tid;
    logic [3:0] s0_off, s1_off;
    logic       s0_odd, s1_odd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_tid   <= '0;
            s0_off   <= '0;
            s0_odd   <= 1'b0;
            s1_valid <= 1'b0;
            s1_tid   <= '0;
            s1_off   <= '0;
            s1_odd   <= 1'b0;
        end else begin
            s0_valid <= rd_hit;
            s0_tid   <= mmio.mmio_rd_tid;
            s0_off   <= rd_rel[4:1];
            s0_odd   <= rd_rel[0];
            s1_valid <= s0_valid;
            s1_tid   <= s0_tid;
            s1_off   <= s0_off;
            s1_odd   <= s0_odd;
        end
    end

    logic [63:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (!s1_odd) begin
            case (s1_off)
                CCI_MPF_CSR_OFF_DFH:              rd_data = CCI_MPF_CSR_DFH;
                CCI_MPF_CSR_OFF_VTP_MODE:         rd_data = 64'(vtp_in_mode);
                CCI_MPF_CSR_OFF_PT_BASE:          rd_data = 64'(vtp_in_page_table_base);
                CCI_MPF_CSR_OFF_WRO_WRITES:       rd_data = wro_num_writes;
                CCI_MPF_CSR_OFF_WRO_READS:        rd_data = wro_num_reads;
                CCI_MPF_CSR_OFF_WRO_WR_CONFLICTS: rd_data = wro_num_write_conflicts;
                CCI_MPF_CSR_OFF_WRO_RD_CONFLICTS: rd_data = wro_num_read_conflicts;
                default: ;
            endcase
            if (s1_off >= CCI_MPF_CSR_OFF_EVT_BASE &&
                s1_off <  CCI_MPF_CSR_OFF_EVT_BASE + 4'(CCI_MPF_CSR_NUM_EVENTS)) begin
                rd_data = evt_cnt[3'(s1_off - CCI_MPF_CSR_OFF_EVT_BASE)];
            end
        end
    end

    // Response FIFO; a push that finds it full with no pop is dropped.
    logic [CCI_MPF_CSR_RSP_W-1:0] rsp_entry;
    logic                         fifo_not_empty;
    logic                         fifo_full;
    logic                         pop;
    logic                         overflow;

    assign pop = mmio.rsp_ready && fifo_not_empty;

    cci_mpf_csr_rsp_fifo #(
        .WIDTH (CCI_MPF_CSR_RSP_W),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .enq_data ({s1_tid, rd_data}),
        .enq_en   (s1_valid),
        .deq_en   (pop),
        .first    (rsp_entry),
        .notEmpty (fifo_not_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (s1_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign mmio.rsp_valid    = fifo_not_empty;
    assign mmio.rsp_tid      = rsp_entry[72:64];
    assign mmio.rsp_data     = rsp_entry[63:0];
    assign mmio.rsp_overflow = overflow;

endmodule
